// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle left/right shifter with logical or arithmetic fill.
// The operand is loaded into a wider result register and shifted by up to STEP
// bits per cycle. Oversize shift amounts are clamped to OUT_W so the latency
// never exceeds ceil(OUT_W/STEP)+1 cycles.
module iter_shifter #(
  parameter int IN_W    = 24,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 8,
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               direction,
  input  logic               arith,
  input  logic [IN_W-1:0]    in,
  input  logic [SHAMT_W-1:0] shift,
  output logic [OUT_W-1:0]   shifted,
  output logic               busy,
  output logic               ready
);

  // The counter must be able to hold OUT_W itself, the clamped maximum.
  localparam int CTR_W = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   shifted_q, shifted_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [CTR_W-1:0]   step_k;
  logic               dir_q, dir_d;
  logic               arith_q, arith_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  // Widen the operand; sign fill only applies to arithmetic right shifts.
  function automatic logic [OUT_W-1:0] extend_operand(input logic [IN_W-1:0] op,
                                                       input logic          sign_fill);
    logic [OUT_W-1:0] r;
    r            = '0;
    r[IN_W-1:0]  = op;
    for (int i = IN_W; i < OUT_W; i++) begin
      r[i] = sign_fill & op[IN_W-1];
    end
    return r;
  endfunction

  // Saturate the requested amount at OUT_W; anything larger gives the same result.
  function automatic logic [CTR_W-1:0] clamp_shift(input logic [SHAMT_W-1:0] amt);
    if (int'(amt) >= OUT_W) begin
      return CTR_W'(OUT_W);
    end
    return CTR_W'(amt);
  endfunction

  // One step of k bits; the arithmetic fill replicates the current MSB.
  function automatic logic [OUT_W-1:0] shift_step(input logic [OUT_W-1:0] value,
                                                   input logic [CTR_W-1:0] k,
                                                   input logic             left,
                                                   input logic             sign_fill);
    logic [OUT_W-1:0] r;
    if (left) begin
      r = value << k;
    end else if (sign_fill) begin
      r = $signed(value) >>> k;
    end else begin
      r = value >> k;
    end
    return r;
  endfunction

  // Next-state logic: load on an accepted start, step while ctr is non-zero.
  always_comb begin
    state_d   = state_q;
    shifted_d = shifted_q;
    ctr_d     = ctr_q;
    dir_d     = dir_q;
    arith_d   = arith_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    step_k    = (ctr_q > CTR_W'(STEP)) ? CTR_W'(STEP) : ctr_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shifted_d = extend_operand(in, arith & ~direction);
          ctr_d     = clamp_shift(shift);
          dir_d     = direction;
          arith_d   = arith;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (ctr_q == '0) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          shifted_d = shift_step(shifted_q, step_k, dir_q, arith_q);
          ctr_d     = ctr_q - step_k;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shifted_q <= '0;
      ctr_q     <= '0;
      dir_q     <= 1'b0;
      arith_q   <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shifted_q <= shifted_d;
      ctr_q     <= ctr_d;
      dir_q     <= dir_d;
      arith_q   <= arith_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign shifted = shifted_q;
  assign busy    = busy_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Testbench for iter_shifter: table of directed vectors, random vectors checked
// against a single-shot reference, and hand-written handshake/reset sequences.
module tb_iter_shifter;

  localparam int IN_W    = 24;
  localparam int OUT_W   = 32;
  localparam int SHAMT_W = 8;
  localparam int STEP    = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               direction = 1'b0;
  logic               arith = 1'b0;
  logic [IN_W-1:0]    in_v = '0;
  logic [SHAMT_W-1:0] shift = '0;
  logic [OUT_W-1:0]   shifted;
  logic               busy;
  logic               ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        dir;
    logic        ar;
    logic [23:0] op;
    logic [7:0]  sh;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } sb_t;

  sb_t sb_q[$];

  always #5 clk = ~clk;

  iter_shifter #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHAMT_W(SHAMT_W), .STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .direction(direction),
    .arith(arith), .in(in_v), .shift(shift), .shifted(shifted),
    .busy(busy), .ready(ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [7:0] sh);
    int n;
    n = (int'(sh) > OUT_W) ? OUT_W : int'(sh);
    return (n + STEP - 1) / STEP + 1;
  endfunction

  // Whole-amount reference: one shift by the clamped amount.
  function automatic logic [31:0] ref_model(input logic dir, input logic ar,
                                            input logic [23:0] op, input logic [7:0] sh);
    int n;
    logic signed [31:0] x;
    logic signed [31:0] r;
    n = (int'(sh) > OUT_W) ? OUT_W : int'(sh);
    if (!dir && ar) x = {{8{op[23]}}, op};
    else            x = {8'h00, op};
    if (dir)     r = x << n;
    else if (ar) r = x >>> n;
    else         r = x >> n;
    return r;
  endfunction

  // Drive one start, push the expectation, then scramble the operands.
  task automatic launch(input logic dir, input logic ar, input logic [23:0] op,
                        input logic [7:0] sh, input logic [31:0] exp);
    sb_t e;
    start     = 1'b1;
    direction = dir;
    arith     = ar;
    in_v      = op;
    shift     = sh;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.res = exp;
    e.lat = lat_of(sh);
    sb_q.push_back(e);
    chk("accept_busy", {31'b0, busy}, 32'd1);
    chk("accept_ready", {31'b0, ready}, 32'd0);
    in_v      = IN_W'($urandom);
    shift     = SHAMT_W'($urandom);
    direction = ~dir;
    arith     = ~ar;
  endtask

  // Wait for ready (bounded), optionally pulsing a foreign start at cycle inject.
  task automatic wait_done(input string name, input int inject);
    sb_t e;
    int cyc;
    int bcnt;
    cyc  = 0;
    bcnt = 1;
    while (!ready && cyc < 20) begin
      if (cyc == inject) begin
        start     = 1'b1;
        in_v      = 24'h5A5A5A;
        shift     = 8'd0;
        direction = 1'b0;
        arith     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
    end
    start = 1'b0;
    chk({name, "_ready"}, {31'b0, ready}, 32'd1);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard actual=empty expected=entry", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_lat"}, 32'(cyc), 32'(e.lat));
      chk({name, "_busy_cycles"}, 32'(bcnt), 32'(e.lat));
      chk({name, "_result"}, shifted, e.res);
    end
  endtask

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 24'h000001, 8'd31,  32'h80000000};
    tbl[1]  = '{1'b0, 1'b1, 24'h800000, 8'd4,   32'hFFF80000};
    tbl[2]  = '{1'b0, 1'b0, 24'hFFFFFF, 8'd40,  32'h00000000};
    tbl[3]  = '{1'b0, 1'b1, 24'hFFFFFF, 8'd40,  32'hFFFFFFFF};
    tbl[4]  = '{1'b1, 1'b0, 24'h123456, 8'd0,   32'h00123456};
    tbl[5]  = '{1'b0, 1'b0, 24'h123456, 8'd0,   32'h00123456};
    tbl[6]  = '{1'b1, 1'b0, 24'hABCDEF, 8'd8,   32'hABCDEF00};
    tbl[7]  = '{1'b0, 1'b0, 24'hABCDEF, 8'd5,   32'h00055E6F};
    tbl[8]  = '{1'b1, 1'b1, 24'h800000, 8'd1,   32'h01000000};
    tbl[9]  = '{1'b0, 1'b1, 24'h7FFFFF, 8'd3,   32'h000FFFFF};
    tbl[10] = '{1'b1, 1'b0, 24'hFFFFFF, 8'd255, 32'h00000000};
    tbl[11] = '{1'b0, 1'b1, 24'h800001, 8'd32,  32'hFFFFFFFF};
    tbl[12] = '{1'b0, 1'b1, 24'h900000, 8'd7,   32'hFFFF2000};
    tbl[13] = '{1'b1, 1'b0, 24'hFFFFFF, 8'd12,  32'hFFFFF000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_shifted", shifted, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_ready", {31'b0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back-to-back from DONE
    for (int i = 0; i < 14; i++) begin
      launch(tbl[i].dir, tbl[i].ar, tbl[i].op, tbl[i].sh, tbl[i].exp);
      wait_done($sformatf("vec%0d", i), -1);
    end

    // Random vectors against the reference
    for (int i = 0; i < 20; i++) begin
      logic        d, a;
      logic [23:0] op;
      logic [7:0]  sh;
      d  = 1'($urandom_range(0, 1));
      a  = 1'($urandom_range(0, 1));
      op = 24'($urandom);
      sh = 8'($urandom_range(0, 45));
      launch(d, a, op, sh, ref_model(d, a, op, sh));
      wait_done($sformatf("rnd%0d", i), -1);
    end

    // Start pulsed mid-SHIFT is ignored
    launch(1'b1, 1'b0, 24'h000001, 8'd31, 32'h80000000);
    wait_done("mid_start", 3);

    // Asynchronous reset between clock edges
    launch(1'b0, 1'b0, 24'hFFFFFF, 8'd20, 32'h0000000F);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_shifted", shifted, 32'h0);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_ready", {31'b0, ready}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_ready", {31'b0, ready}, 32'd0);
    chk("post_rst_shifted", shifted, 32'h0);

    // Recovery after reset
    launch(1'b0, 1'b1, 24'h800000, 8'd4, 32'hFFF80000);
    wait_done("post_rst_op", -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
